// File: rtl/reorder_buffer_pkg.sv
// Shared types for the LC-3b Tomasulo reorder buffer.
//   lc3b_reg / lc3b_word / lc3b_rob_addr : basic field widths
//   cdb_t       : common data bus broadcast {valid, data, tag}
//   rob_entry_t : one reorder buffer slot
package reorder_buffer_pkg;

    localparam int ROB_DEPTH = 8;
    localparam int WORD_W    = 16;

    typedef logic [2:0]        lc3b_reg;
    typedef logic [WORD_W-1:0] lc3b_word;
    typedef logic [2:0]        lc3b_rob_addr;

    typedef struct packed {
        logic         valid;
        lc3b_word     data;
        lc3b_rob_addr tag;
    } cdb_t;

    typedef struct packed {
        logic     valid;
        logic     ready;
        logic     regwrite;
        lc3b_reg  dest;
        lc3b_word data;
        logic     mispredict;
        lc3b_word target;
    } rob_entry_t;

endpackage

// File: rtl/rob_read_port.sv
// Single operand lookup into the reorder buffer with CDB bypass.
//   tag         : ROB tag being looked up
//   cdb         : current CDB broadcast
//   entry_*     : fields of the entry selected by tag
//   ready, data : operand availability and value
module rob_read_port
    import reorder_buffer_pkg::*;
(
    input  lc3b_rob_addr tag,
    input  cdb_t         cdb,
    input  logic         entry_valid,
    input  logic         entry_ready,
    input  lc3b_word     entry_data,
    output logic         ready,
    output lc3b_word     data
);

    // A broadcast this cycle wins over the stored copy so dispatch does not
    // miss a value that lands in the entry only at the next edge.
    always_comb begin
        ready = entry_valid & entry_ready;
        data  = entry_data;
        if (cdb.valid && (cdb.tag == tag)) begin
            ready = 1'b1;
            data  = cdb.data;
        end
    end

endmodule

// File: rtl/reorder_buffer.sv
// 8-entry circular reorder buffer for the Tomasulo LC-3b core.
//   alloc_*      : in-order allocation from dispatch, alloc_tag = tail
//   cdb_in       : out-of-order result write-back
//   br_*         : branch resolution (mispredict flag and correct target)
//   rd_*_a/_b    : two operand lookups with CDB bypass
//   commit_*     : single in-order retirement from head
//   flush/flush_pc : squash and redirect when a mispredicted branch retires
//   full/empty   : occupancy status
module reorder_buffer
    import reorder_buffer_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         alloc_valid,
    input  logic         alloc_regwrite,
    input  lc3b_reg      alloc_dest,
    input  logic         alloc_ready,
    output lc3b_rob_addr alloc_tag,
    output logic         full,
    output logic         empty,
    input  cdb_t         cdb_in,
    input  logic         br_valid,
    input  lc3b_rob_addr br_tag,
    input  logic         br_mispredict,
    input  lc3b_word     br_target,
    input  lc3b_rob_addr rd_tag_a,
    input  lc3b_rob_addr rd_tag_b,
    output logic         rd_ready_a,
    output logic         rd_ready_b,
    output lc3b_word     rd_data_a,
    output lc3b_word     rd_data_b,
    output logic         commit_valid,
    output logic         commit_regwrite,
    output lc3b_reg      commit_dest,
    output lc3b_word     commit_data,
    output lc3b_rob_addr commit_tag,
    output logic         flush,
    output lc3b_word     flush_pc
);

    rob_entry_t   entries_reg [ROB_DEPTH];
    lc3b_rob_addr head_reg;
    lc3b_rob_addr tail_reg;
    logic [3:0]   count_reg;
    logic [3:0]   count_next;

    logic       alloc_accept;
    logic       cdb_hit;
    logic       br_hit;
    rob_entry_t head_entry;
    rob_entry_t alloc_entry;

    assign head_entry = entries_reg[head_reg];

    assign full  = (count_reg == 4'd8);
    assign empty = (count_reg == 4'd0);
    assign alloc_tag = tail_reg;

    assign commit_valid    = head_entry.valid & head_entry.ready;
    assign commit_regwrite = head_entry.regwrite;
    assign commit_dest     = head_entry.dest;
    assign commit_data     = head_entry.data;
    assign commit_tag      = head_reg;

    assign flush    = commit_valid & head_entry.mispredict;
    assign flush_pc = head_entry.target;

    // A commit in the same cycle does not free a slot for a full ROB.
    assign alloc_accept = alloc_valid & ~full & ~flush;
    assign cdb_hit = cdb_in.valid & entries_reg[cdb_in.tag].valid & ~entries_reg[cdb_in.tag].ready;
    assign br_hit  = br_valid & entries_reg[br_tag].valid;

    always_comb begin
        alloc_entry            = '0;
        alloc_entry.valid      = 1'b1;
        alloc_entry.ready      = alloc_ready;
        alloc_entry.regwrite   = alloc_regwrite;
        alloc_entry.dest       = alloc_dest;
        alloc_entry.mispredict = 1'b0;
    end

    always_comb begin
        count_next = count_reg;
        if (alloc_accept && !commit_valid) begin
            count_next = count_reg + 4'd1;
        end else if (!alloc_accept && commit_valid) begin
            count_next = count_reg - 4'd1;
        end
    end

    // Alloc only targets the tail slot, which is invalid whenever alloc is
    // accepted, so it never collides with CDB/branch updates (those need a
    // valid entry). Branch and commit touch disjoint fields of the head.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
            for (int i = 0; i < ROB_DEPTH; i++) begin
                entries_reg[i] <= '0;
            end
        end else if (flush) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
            for (int i = 0; i < ROB_DEPTH; i++) begin
                entries_reg[i].valid <= 1'b0;
            end
        end else begin
            if (cdb_hit) begin
                entries_reg[cdb_in.tag].data  <= cdb_in.data;
                entries_reg[cdb_in.tag].ready <= 1'b1;
            end
            if (br_hit) begin
                entries_reg[br_tag].ready      <= 1'b1;
                entries_reg[br_tag].mispredict <= br_mispredict;
                entries_reg[br_tag].target     <= br_target;
            end
            if (commit_valid) begin
                entries_reg[head_reg].valid <= 1'b0;
                head_reg <= head_reg + 3'd1;
            end
            if (alloc_accept) begin
                entries_reg[tail_reg] <= alloc_entry;
                tail_reg <= tail_reg + 3'd1;
            end
            count_reg <= count_next;
        end
    end

    // Two identical operand lookups.
    lc3b_rob_addr rd_tag_sel   [2];
    logic         rd_ready_sel [2];
    lc3b_word     rd_data_sel  [2];

    assign rd_tag_sel[0] = rd_tag_a;
    assign rd_tag_sel[1] = rd_tag_b;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rd
            rob_read_port u_port (
                .tag         (rd_tag_sel[gi]),
                .cdb         (cdb_in),
                .entry_valid (entries_reg[rd_tag_sel[gi]].valid),
                .entry_ready (entries_reg[rd_tag_sel[gi]].ready),
                .entry_data  (entries_reg[rd_tag_sel[gi]].data),
                .ready       (rd_ready_sel[gi]),
                .data        (rd_data_sel[gi])
            );
        end
    endgenerate

    assign rd_ready_a = rd_ready_sel[0];
    assign rd_data_a  = rd_data_sel[0];
    assign rd_ready_b = rd_ready_sel[1];
    assign rd_data_b  = rd_data_sel[1];

endmodule
